// File: rtl/blackbox_pkg.sv
`default_nettype none
// ============================================================================
// blackbox_pkg : shared FSM state type and width helpers for blackbox_sweep
// Rev 1.0
// ============================================================================
package blackbox_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_HOLD    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Truth-table depth for an n_in-input box.
    function automatic int tbl_w(input int n_in);
        return 1 << n_in;
    endfunction

    // One extra bit lets the vector index reach the terminal value without wrapping.
    function automatic int idx_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/blackbox_lut.sv
`default_nettype none
// ============================================================================
// blackbox_lut : truth-table register with load enable and a combinational read
// Rev 1.0
// ============================================================================
module blackbox_lut
    import blackbox_pkg::*;
#(
    parameter int N_IN  = 3,
    localparam int TBL_W = tbl_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [TBL_W-1:0] table_i,
    input  logic [N_IN-1:0]  addr_i,
    output logic             rd_o
);

    logic [TBL_W-1:0] table_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= '0;
        end else if (we_i) begin
            table_q <= table_i;
        end
    end

    assign rd_o = table_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/blackbox_sweep.sv
`default_nettype none
// ============================================================================
// blackbox_sweep : programmable N-input box with exhaustive self-checking sweep
// Rev 1.0
// ============================================================================
module blackbox_sweep
    import blackbox_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 10,
    localparam int TBL_W      = tbl_w(N_IN),
    localparam int IDX_W      = idx_w(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [TBL_W-1:0] cfg_table,
    input  logic [TBL_W-1:0] exp_table,
    input  logic             start,
    input  logic [N_IN-1:0]  ext_in,
    output logic             ext_out,
    output logic [N_IN-1:0]  stim,
    output logic             busy,
    output logic             done,
    output logic [TBL_W-1:0] result,
    output logic [IDX_W-1:0] mismatch_cnt,
    output logic             fail,
    output logic [N_IN-1:0]  first_fail_idx
);

    localparam int               CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TBL_W - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] hold_q;
    logic [N_IN-1:0]  stim_q;
    logic [N_IN-1:0]  ffi_q;
    logic [TBL_W-1:0] result_q;
    logic [IDX_W-1:0] mm_q;
    logic             busy_q;
    logic             done_q;
    logic             fail_q;
    logic             ext_out_q;

    logic             accept_w;
    logic [N_IN-1:0]  lut_addr_w;
    logic             lut_rd_w;

    assign accept_w   = (state_q == S_IDLE) || (state_q == S_DONE);
    // The sweep owns the single read port whenever it is running.
    assign lut_addr_w = busy_q ? stim_q : ext_in;

    blackbox_lut #(
        .N_IN    (N_IN)
    ) u_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_we & accept_w),
        .table_i (cfg_table),
        .addr_i  (lut_addr_w),
        .rd_o    (lut_rd_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            stim_q    <= '0;
            ffi_q     <= '0;
            result_q  <= '0;
            mm_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            ext_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    ext_out_q <= lut_rd_w;
                    if (start) begin
                        result_q <= '0;
                        mm_q     <= '0;
                        fail_q   <= 1'b0;
                        ffi_q    <= '0;
                        done_q   <= 1'b0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    stim_q  <= idx_q[N_IN-1:0];
                    hold_q  <= HOLD_INIT;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (hold_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result_q[idx_q[N_IN-1:0]] <= lut_rd_w;
                    if (lut_rd_w != exp_table[idx_q[N_IN-1:0]]) begin
                        mm_q <= mm_q + 1'b1;
                        if (!fail_q) begin
                            ffi_q  <= idx_q[N_IN-1:0];
                            fail_q <= 1'b1;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= S_APPLY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ext_out        = ext_out_q;
    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign mismatch_cnt   = mm_q;
    assign fail           = fail_q;
    assign first_fail_idx = ffi_q;

endmodule
`default_nettype wire

// File: tb/tb_blackbox_sweep.sv
`default_nettype none
// ============================================================================
// tb_blackbox_sweep : directed self-checking bench for blackbox_sweep (N=3, H=10)
// Rev 1.0
// ============================================================================
module tb_blackbox_sweep;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_table;
    logic [7:0] exp_table;
    logic       start;
    logic [2:0] ext_in;
    logic       ext_out;
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] mismatch_cnt;
    logic       fail;
    logic [2:0] first_fail_idx;

    int checks   = 0;
    int failures = 0;
    int cyc;

    always #5 clk = ~clk;

    blackbox_sweep #(
        .N_IN           (3),
        .HOLD_CYCLES    (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_we         (cfg_we),
        .cfg_table      (cfg_table),
        .exp_table      (exp_table),
        .start          (start),
        .ext_in         (ext_in),
        .ext_out        (ext_out),
        .stim           (stim),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .mismatch_cnt   (mismatch_cnt),
        .fail           (fail),
        .first_fail_idx (first_fail_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Caller raises start (and optionally cfg_we) at a negedge before calling.
    // inject_at > 0: at that busy cycle either pulse start+cfg_we(0x00) or, if
    // do_reset, assert rst_n and stop tracking.
    task automatic run_sweep(input int inject_at, input bit do_reset, output int n);
        n = 0;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            if (n % 12 == 2) chk("stim_step", {29'd0, stim}, (n - 2) / 12);
            if (n == inject_at) begin
                if (do_reset) begin
                    chk("mid_mismatch", {28'd0, mismatch_cnt}, 32'd3);
                    chk("mid_fail", {31'd0, fail}, 32'd1);
                    rst_n = 1'b0;
                    #1;
                    break;
                end else begin
                    start     = 1'b1;
                    cfg_we    = 1'b1;
                    cfg_table = 8'h00;
                end
            end else begin
                start  = 1'b0;
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset with random inputs
        rst_n     = 1'b0;
        cfg_we    = 1'($urandom);
        cfg_table = 8'($urandom);
        exp_table = 8'($urandom);
        start     = 1'($urandom);
        ext_in    = 3'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_mismatch", {28'd0, mismatch_cnt}, 32'd0);
        chk("rst_fail", {31'd0, fail}, 32'd0);
        chk("rst_stim", {29'd0, stim}, 32'd0);
        chk("rst_ffi", {29'd0, first_fail_idx}, 32'd0);
        chk("rst_ext_out", {31'd0, ext_out}, 32'd0);
        cfg_we = 1'b0;
        start  = 1'b0;
        ext_in = 3'b111;
        rst_n  = 1'b1;
        @(negedge clk);
        chk("cleared_table_ext_out", {31'd0, ext_out}, 32'd0);

        // Clean majority sweep; load and start in the same cycle
        cfg_table = 8'hE8;
        exp_table = 8'hE8;
        cfg_we    = 1'b1;
        start     = 1'b1;
        run_sweep(0, 1'b0, cyc);
        chk("clean_cycles", cyc, 32'd96);
        chk("clean_result", {24'd0, result}, 32'hE8);
        chk("clean_mismatch", {28'd0, mismatch_cnt}, 32'd0);
        chk("clean_fail", {31'd0, fail}, 32'd0);
        chk("clean_done", {31'd0, done}, 32'd1);
        chk("clean_stim_last", {29'd0, stim}, 32'd7);

        // Single mismatch at vector 6
        exp_table = 8'hA8;
        start     = 1'b1;
        @(posedge clk);
        #1;
        chk("start_clears_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        chk("one_result", {24'd0, result}, 32'hE8);
        chk("one_mismatch", {28'd0, mismatch_cnt}, 32'd1);
        chk("one_fail", {31'd0, fail}, 32'd1);
        chk("one_ffi", {29'd0, first_fail_idx}, 32'd6);

        // Every vector mismatches
        exp_table = 8'h17;
        start     = 1'b1;
        run_sweep(0, 1'b0, cyc);
        chk("all_cycles", cyc, 32'd96);
        chk("all_mismatch", {28'd0, mismatch_cnt}, 32'd8);
        chk("all_ffi", {29'd0, first_fail_idx}, 32'd0);
        chk("all_fail", {31'd0, fail}, 32'd1);

        // start and cfg_we ignored mid-sweep
        exp_table = 8'hE8;
        start     = 1'b1;
        run_sweep(40, 1'b0, cyc);
        chk("busy_ign_cycles", cyc, 32'd96);
        chk("busy_ign_result", {24'd0, result}, 32'hE8);
        chk("busy_ign_mismatch", {28'd0, mismatch_cnt}, 32'd0);
        chk("busy_ign_done", {31'd0, done}, 32'd1);

        // Direct mode on table 0xE8
        ext_in = 3'b011;
        @(negedge clk);
        chk("direct_011", {31'd0, ext_out}, 32'd1);
        ext_in = 3'b100;
        @(negedge clk);
        chk("direct_100", {31'd0, ext_out}, 32'd0);

        // Reset mid-sweep at cycle 40
        exp_table = 8'h17;
        start     = 1'b1;
        run_sweep(40, 1'b1, cyc);
        chk("abort_cycle", cyc, 32'd40);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_mismatch", {28'd0, mismatch_cnt}, 32'd0);
        chk("abort_fail", {31'd0, fail}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        ext_in = 3'b111;
        @(negedge clk);
        chk("abort_table_cleared", {31'd0, ext_out}, 32'd0);

        // Reload and run a clean sweep after the abort
        cfg_table = 8'hE8;
        exp_table = 8'hE8;
        cfg_we    = 1'b1;
        start     = 1'b1;
        run_sweep(0, 1'b0, cyc);
        chk("post_cycles", cyc, 32'd96);
        chk("post_result", {24'd0, result}, 32'hE8);
        chk("post_mismatch", {28'd0, mismatch_cnt}, 32'd0);
        chk("post_fail", {31'd0, fail}, 32'd0);
        chk("post_done", {31'd0, done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blackbox_sweep.md
Name: blackbox_sweep

Overview:
Parametrised successor to the fixed 3-input combinational black box. It holds a programmable N-input truth table (the "box") and an on-chip sweep engine. The engine applies all 2^N input vectors in ascending order, holds each one for a programmable number of cycles, and captures the box output. Captured results are compared against a golden table, and the block reports the result vector, the mismatch count and the index of the first failure. It sits in the lab datapath as a self-checking replacement for an exhaustive testbench sweep. When idle, it also serves as a registered N-input lookup function.

Parameters:
- N_IN, 3, number of box inputs; table depth is 2^N_IN (legal range 1..8).
- HOLD_CYCLES, 10, cycles each stimulus is held before capture (legal range >= 1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  load cfg_table into the box truth table; honoured only when not busy.
- cfg_table  in  2^N_IN  truth table; bit i is the output for input vector i.
- exp_table  in  2^N_IN  golden expected outputs; sampled at each capture.
- start  in  1  start a sweep; honoured only when not busy.
- ext_in  in  N_IN  direct-mode input vector.
- ext_out  out  1  registered direct-mode output.
- stim  out  N_IN  vector currently applied during a sweep.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until the next start or reset.
- result  out  2^N_IN  captured outputs; bit i belongs to vector i.
- mismatch_cnt  out  N_IN+1  number of vectors where result differs from exp_table.
- fail  out  1  set when any mismatch occurs in the current sweep.
- first_fail_idx  out  N_IN  lowest failing vector index; valid only when fail=1.

Behaviour:
Reset (asynchronous, rst_n=0):
- Truth table, result, mismatch_cnt, stim, first_fail_idx all clear to 0.
- busy, done, fail, ext_out all clear to 0.
- FSM goes to IDLE.
- A reset mid-sweep aborts the sweep immediately; no partial state survives.

FSM states: IDLE, APPLY, HOLD, CAPTURE, DONE.
- IDLE/DONE:
  - cfg_we=1 loads the truth table at the clock edge.
  - ext_out <= table[ext_in] every cycle (1-cycle latency).
  - start=1 clears result, mismatch_cnt, fail, first_fail_idx and done; sets idx=0 and goes to APPLY.
  - If start and cfg_we are asserted in the same cycle, the table loads first and the sweep uses the new table.
- APPLY:
  - stim <= idx; hold counter <= HOLD_CYCLES-1; busy=1; next state HOLD.
- HOLD:
  - Decrement the hold counter; go to CAPTURE when it reaches 0.
  - Each vector therefore spends exactly HOLD_CYCLES cycles in HOLD.
- CAPTURE:
  - result[idx] <= table[stim].
  - If table[stim] != exp_table[idx]: mismatch_cnt increments; if fail=0, then first_fail_idx <= idx and fail <= 1.
  - If idx == 2^N_IN-1, go to DONE. Otherwise idx increments and the FSM goes to APPLY.
- DONE:
  - busy=0 and done=1.
  - Outputs hold until the next start.
  - Behaves like IDLE for cfg_we, start and ext_out.

While busy:
- cfg_we and start are ignored.
- ext_out holds its last value.

Timing and width rules:
- Cycles per vector = HOLD_CYCLES+2.
- Total sweep = 2^N_IN*(HOLD_CYCLES+2) cycles from the start edge to the done rising edge.
- The idx counter is N_IN+1 bits wide so the terminal test needs no wrap.
- mismatch_cnt saturates naturally at 2^N_IN, which fits in N_IN+1 bits.
- exp_table may change during a sweep; each bit is sampled only at its own CAPTURE.

Decomposition:
- Package blackbox_pkg contains:
  - the FSM state enum;
  - the TBL_W = 2^N_IN width helper;
  - the IDX_W = N_IN+1 width helper.
- Sub-module blackbox_lut: truth-table register with load enable and async clear, plus a combinational read mux (table[addr]). It is instantiated once. Direct mode and sweep share its read port through a mux on busy.

Test Plan (N_IN=3, HOLD_CYCLES=10):
1. Assert rst_n=0 with random inputs -> all outputs 0; after release, ext_in=3'b111 gives ext_out=0 (table cleared).
2. Load cfg_table=8'hE8 (majority), exp_table=8'hE8, pulse start -> busy for exactly 96 cycles; stim steps 0..7; then result=8'hE8, mismatch_cnt=0, fail=0, done=1.
3. Table 8'hE8, exp_table=8'hA8, start -> result=8'hE8, mismatch_cnt=1, fail=1, first_fail_idx=6; with exp_table=8'h17 -> mismatch_cnt=8, first_fail_idx=0.
4. During a sweep, pulse start and cfg_we with cfg_table=8'h00 -> both ignored; the sweep completes with result=8'hE8 in 96 cycles.
5. Direct mode, table 8'hE8: ext_in=3'b011 -> ext_out=1 one cycle later; ext_in=3'b100 -> ext_out=0 one cycle later.
6. Assert rst_n=0 at cycle 40 of a sweep -> busy, done, result and mismatch_cnt are 0 immediately; a reload plus start then runs a full clean 96-cycle sweep.
